// File: rtl/mutation_controller.sv
// Mutation pass sequencer: read child, build an LFSR-driven keep-mask, hand off to the mutation unit, write back.
// Optional build macro MUTATION_ELITE_EN: index 0 (the elite) is never read, mutated or written.
//
// state  | meaning
// IDLE   | waiting for start
// READ   | population read issued for idx
// LATCH  | read data captured as the child
// GEN    | one LFSR step and one mask bit per cycle
// MUTATE | one-cycle handoff to the mutation unit
// WAIT   | waiting for mut_done, bounded by a 16-cycle timeout
// WRITE  | result written back to idx
// DONE   | one-cycle completion pulse
module mutation_controller #(
  parameter  int CHROMOSOME_WIDTH = 8,
  parameter  int POP_SIZE         = 16,
  localparam int ADDR_WIDTH       = $clog2(POP_SIZE)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [7:0]                  mutation_rate,
  input  logic [15:0]                 lfsr_seed,
  output logic                        rd_en,
  output logic [ADDR_WIDTH-1:0]       rd_addr,
  input  logic [CHROMOSOME_WIDTH-1:0] rd_data,
  output logic                        wr_en,
  output logic [ADDR_WIDTH-1:0]       wr_addr,
  output logic [CHROMOSOME_WIDTH-1:0] wr_data,
  output logic                        mut_start,
  output logic [CHROMOSOME_WIDTH-1:0] mut_child,
  output logic [CHROMOSOME_WIDTH-1:0] mut_mask,
  output logic [7:0]                  mut_rate,
  input  logic [CHROMOSOME_WIDTH-1:0] mut_child_out,
  input  logic                        mut_done,
  output logic                        busy,
  output logic                        done,
  output logic                        error,
  output logic [ADDR_WIDTH:0]         mutated_count
);

  localparam int GW = (CHROMOSOME_WIDTH > 1) ? $clog2(CHROMOSOME_WIDTH) : 1;
  localparam logic [GW-1:0]         GEN_LAST  = GW'(CHROMOSOME_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(POP_SIZE - 1);
  localparam logic [15:0]           LFSR_INIT = 16'hACE1;
  localparam logic [15:0]           LFSR_TAPS = 16'hB400;
  localparam logic [3:0]            WAIT_LAST = 4'd15;
`ifdef MUTATION_ELITE_EN
  localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = ADDR_WIDTH'(1);
`else
  localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = '0;
`endif

  typedef enum logic [2:0] {
    IDLE, READ, LATCH, GEN, MUTATE, WAIT, WRITE, DONE
  } state_t;

  state_t                      state_q, state_d;
  logic [ADDR_WIDTH-1:0]       idx_q, idx_d;
  logic [CHROMOSOME_WIDTH-1:0] child_q, child_d;
  logic [CHROMOSOME_WIDTH-1:0] mask_q, mask_d;
  logic [CHROMOSOME_WIDTH-1:0] result_q, result_d;
  logic [GW-1:0]               gen_cnt_q, gen_cnt_d;
  logic [3:0]                  wait_cnt_q, wait_cnt_d;
  logic [15:0]                 lfsr_q, lfsr_d;
  logic [ADDR_WIDTH:0]         count_q, count_d;
  logic                        error_q, error_d;
  logic [15:0]                 lfsr_next;
  logic [CHROMOSOME_WIDTH:0]   mask_shift;
  logic                        run;

  assign lfsr_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      child_q    <= '0;
      mask_q     <= '0;
      result_q   <= '0;
      gen_cnt_q  <= '0;
      wait_cnt_q <= '0;
      lfsr_q     <= LFSR_INIT;
      count_q    <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      child_q    <= child_d;
      mask_q     <= mask_d;
      result_q   <= result_d;
      gen_cnt_q  <= gen_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      lfsr_q     <= lfsr_d;
      count_q    <= count_d;
      error_q    <= error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    child_d    = child_q;
    mask_d     = mask_q;
    result_d   = result_q;
    gen_cnt_d  = gen_cnt_q;
    wait_cnt_d = wait_cnt_q;
    lfsr_d     = lfsr_q;
    count_d    = count_q;
    error_d    = error_q;
    // new mask bit enters at the MSB so the first GEN cycle ends up in bit 0
    mask_shift = {(lfsr_next[7:0] >= mutation_rate), mask_q};
    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = FIRST_IDX;
          count_d = '0;
          error_d = 1'b0;
          lfsr_d  = (lfsr_seed == 16'h0000) ? LFSR_INIT : lfsr_seed;
          state_d = READ;
        end
      end
      READ: state_d = LATCH;
      LATCH: begin
        child_d   = rd_data;
        gen_cnt_d = GEN_LAST;
        state_d   = GEN;
      end
      GEN: begin
        lfsr_d = lfsr_next;
        mask_d = mask_shift[CHROMOSOME_WIDTH:1];
        if (gen_cnt_q == '0) state_d = MUTATE;
        else gen_cnt_d = gen_cnt_q - 1'b1;
      end
      MUTATE: begin
        wait_cnt_d = WAIT_LAST;
        state_d    = WAIT;
      end
      WAIT: begin
        if (mut_done) begin
          result_d = mut_child_out;
          state_d  = WRITE;
        end else if (wait_cnt_q == '0) begin
          error_d = 1'b1;
          state_d = DONE;
        end else begin
          wait_cnt_d = wait_cnt_q - 1'b1;
        end
      end
      WRITE: begin
        if (mask_q != '1) count_d = count_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = READ;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // outputs are forced quiet while rst is high, even before the reset edge lands
  always_comb begin
    run           = !rst;
    busy          = run && (state_q != IDLE);
    done          = run && (state_q == DONE);
    rd_en         = run && (state_q == READ);
    rd_addr       = rd_en ? idx_q : '0;
    wr_en         = run && (state_q == WRITE);
    wr_addr       = wr_en ? idx_q : '0;
    wr_data       = wr_en ? result_q : '0;
    mut_start     = run && (state_q == MUTATE);
    mut_child     = mut_start ? child_q : '0;
    mut_mask      = mut_start ? mask_q : '0;
    mut_rate      = 8'd1;
    error         = run && error_q;
    mutated_count = run ? count_q : '0;
  end

endmodule

// File: tb/tb_mutation_controller.sv
// Directed bench for mutation_controller with a 4-entry population and a 1-cycle mutation unit model.
// Honours MUTATION_ELITE_EN the same way the design does.
module tb_mutation_controller;

  localparam int CW  = 8;
  localparam int POP = 4;
  localparam int AW  = 2;
`ifdef MUTATION_ELITE_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif
  localparam int NCH = POP - FIRST;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [7:0]    mutation_rate;
  logic [15:0]   lfsr_seed;
  logic          rd_en, wr_en, mut_start, mut_done, busy, done, error;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [CW-1:0] rd_data, wr_data, mut_child, mut_mask, mut_child_out;
  logic [7:0]    mut_rate;
  logic [AW:0]   mutated_count;

  mutation_controller #(.CHROMOSOME_WIDTH(CW), .POP_SIZE(POP)) dut (
    .clk(clk), .rst(rst), .start(start), .mutation_rate(mutation_rate), .lfsr_seed(lfsr_seed),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .mut_start(mut_start), .mut_child(mut_child), .mut_mask(mut_mask), .mut_rate(mut_rate),
    .mut_child_out(mut_child_out), .mut_done(mut_done),
    .busy(busy), .done(done), .error(error), .mutated_count(mutated_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] mem [POP];
  logic       hang;
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  // mutation unit with rate 1: keep bits where mask=1, flip where mask=0
  always @(posedge clk) begin
    mut_done      <= mut_start && !hang;
    mut_child_out <= mut_child ^ ~mut_mask;
  end

  int            wr_n = 0, rd_n = 0, rd0_n = 0, done_n = 0;
  logic [AW-1:0] wa_log [64];
  logic [7:0]    wd_log [64];
  always @(negedge clk) begin
    if (wr_en) begin
      wa_log[wr_n[5:0]] <= wr_addr;
      wd_log[wr_n[5:0]] <= wr_data;
      wr_n <= wr_n + 1;
    end
    if (rd_en) begin
      rd_n <= rd_n + 1;
      if (rd_addr == '0) rd0_n <= rd0_n + 1;
    end
    if (done) done_n <= done_n + 1;
  end

  int n_cmp = 0, n_err = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lstep(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  logic [7:0] exp_data [POP];
  int         exp_cnt;
  int         k;

  task automatic build_expect(input logic [7:0] rate, input logic [15:0] seed);
    logic [15:0] l;
    logic [7:0]  m;
    l = (seed == 16'h0000) ? 16'hACE1 : seed;
    exp_cnt = 0;
    for (int i = FIRST; i < POP; i++) begin
      m = 8'h00;
      for (int b = 0; b < CW; b++) begin
        l    = lstep(l);
        m[b] = (l[7:0] >= rate);
      end
      exp_data[i] = mem[i] ^ ~m;
      if (m != 8'hFF) exp_cnt++;
    end
  endtask

  task automatic do_start(input logic [7:0] rate, input logic [15:0] seed);
    @(negedge clk);
    mutation_rate = rate;
    lfsr_seed     = seed;
    start         = 1'b1;
    @(posedge clk);
    #1;
    k     = cyc;
    start = 1'b0;
  endtask

  // elapsed is the index of the done cycle, counting the cycle that ends at the start edge as 0
  task automatic wait_done(input int budget, input bit spam, output int elapsed);
    elapsed = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        elapsed = cyc + 1 - k;
        start   = 1'b0;
        return;
      end
      start = spam && (i % 5 == 2);
    end
    start = 1'b0;
    check("done_wait_expired", 32'(done), 32'd1);
  endtask

  task automatic run_pass(input logic [7:0] rate, input logic [15:0] seed, input bit spam, input string tag);
    int wb, rb, r0, db, el;
    wb = wr_n; rb = rd_n; r0 = rd0_n; db = done_n;
    build_expect(rate, seed);
    do_start(rate, seed);
    @(negedge clk);
    check({tag, "_busy_run"}, 32'(busy), 32'd1);
    check({tag, "_err_clr"}, 32'(error), 32'd0);
    check({tag, "_cnt_clr"}, 32'(mutated_count), 32'd0);
    wait_done(200, spam, el);
    check({tag, "_done_cycle"}, 32'(el), 32'(1 + NCH * (CW + 5)));
    check({tag, "_mut_cnt"}, 32'(mutated_count), 32'(exp_cnt));
    check({tag, "_err"}, 32'(error), 32'd0);
    @(negedge clk);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check({tag, "_n_wr"}, 32'(wr_n - wb), 32'(NCH));
    check({tag, "_n_rd"}, 32'(rd_n - rb), 32'(NCH));
    check({tag, "_rd0"}, 32'(rd0_n - r0), 32'(FIRST == 0 ? 1 : 0));
    check({tag, "_n_done"}, 32'(done_n - db), 32'd1);
    for (int j = 0; j < NCH && j < (wr_n - wb); j++) begin
      check({tag, "_wa"}, 32'(wa_log[6'(wb + j)]), 32'(FIRST + j));
      check({tag, "_wd"}, 32'(wd_log[6'(wb + j)]), 32'(exp_data[FIRST + j]));
    end
  endtask

  initial begin
    int wb, el, act;
    bit seen;
    rst = 1'b1; start = 1'b0; mutation_rate = 8'd0; lfsr_seed = 16'd0; hang = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_mut_start", 32'(mut_start), 32'd0);
    check("rst_mut_rate", 32'(mut_rate), 32'd1);
    check("rst_error", 32'(error), 32'd0);
    check("rst_count", 32'(mutated_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    run_pass(8'd0, 16'h1234, 1'b0, "rate0");
    for (int i = 0; i < POP; i++) mem[i] = 8'h00;
    run_pass(8'd255, 16'h5A5A, 1'b0, "rate255");
    mem[0] = 8'hA5; mem[1] = 8'h3C; mem[2] = 8'hF0; mem[3] = 8'h0F;
    run_pass(8'd128, 16'hBEEF, 1'b0, "rate128");

    hang = 1'b1;
    wb   = wr_n;
    do_start(8'd0, 16'h0001);
    wait_done(100, 1'b0, el);
    check("to_done_cycle", 32'(el), 32'd28);
    check("to_error", 32'(error), 32'd1);
    @(negedge clk);
    check("to_idle", 32'(busy), 32'd0);
    check("to_err_held", 32'(error), 32'd1);
    repeat (2) @(negedge clk);
    check("to_no_write", 32'(wr_n - wb), 32'd0);
    hang = 1'b0;
    run_pass(8'd0, 16'h0002, 1'b0, "after_to");

    mem[0] = 8'h81; mem[1] = 8'h42; mem[2] = 8'h24; mem[3] = 8'h18;
    do_start(8'd128, 16'h0F0F);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = rd_en && (rd_addr == 2'd2);
    end
    check("rst_mid_reach", 32'(seen), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstm_busy", 32'(busy), 32'd0);
    check("rstm_wr_en", 32'(wr_en), 32'd0);
    check("rstm_count", 32'(mutated_count), 32'd0);
    check("rstm_mut_rate", 32'(mut_rate), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstm_after_busy", 32'(busy), 32'd0);
    act = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy || rd_en || wr_en || mut_start) act++;
    end
    check("rstm_no_resume", 32'(act), 32'd0);
    run_pass(8'd128, 16'h0F0F, 1'b0, "post_rst");

    mem[0] = 8'h5E; mem[1] = 8'hC3; mem[2] = 8'h7A; mem[3] = 8'h19;
    run_pass(8'd128, 16'h0000, 1'b1, "seed0_spam");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mutation_controller.md
MUTATION_CONTROLLER -- requirements
Module: mutation_controller

Interface
REQ-001 The module SHALL have parameter CHROMOSOME_WIDTH, default 8, the chromosome bit width.
REQ-002 The module SHALL have parameter POP_SIZE, default 16, the number of children per pass; ADDR_WIDTH = $clog2(POP_SIZE), derived.
REQ-003 The module SHALL have one clock and a synchronous, active-high reset, with ports as follows:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin one mutation pass; sampled in IDLE only.
- mutation_rate  in  8  per-bit flip threshold, 0-255.
- lfsr_seed  in  16  LFSR seed; sampled on accepted start.
- rd_en / rd_addr  out  1 / ADDR_WIDTH  population read port; data returns one cycle later.
- rd_data  in  CHROMOSOME_WIDTH  population read data.
- wr_en / wr_addr / wr_data  out  1 / ADDR_WIDTH / CHROMOSOME_WIDTH  population write port.
- mut_start  out  1  one-cycle start to the mutation unit.
- mut_child / mut_mask  out  CHROMOSOME_WIDTH each  child and mask to the mutation unit.
- mut_rate  out  8  constant 8'd1 to the mutation unit.
- mut_child_out / mut_done  in  CHROMOSOME_WIDTH / 1  mutation unit result and completion.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse at pass end.
- error  out  1  high when a pass aborted on timeout; held until next accepted start.
- mutated_count  out  ADDR_WIDTH+1  children with at least one flipped bit in the last pass.

Function
REQ-004 The FSM SHALL have states IDLE, READ, LATCH, GEN, MUTATE, WAIT, WRITE and DONE.
REQ-005 In IDLE, start=1 SHALL clear idx, mutated_count and error, load the LFSR with lfsr_seed (16'hACE1 if the seed is 0), and move to READ; start outside IDLE SHALL be ignored.
REQ-006 READ SHALL hold for 1 cycle with rd_en=1 and rd_addr=idx; LATCH SHALL hold for 1 cycle and capture rd_data into the child register.
REQ-007 GEN SHALL last exactly CHROMOSOME_WIDTH cycles; in cycle b, the Galois LFSR (taps 16'hB400) SHALL step once and mask[b] SHALL be set to (lfsr_next[7:0] >= mutation_rate).
REQ-008 The mutation unit flips bit i when mask[i]=0, because mut_rate=1; rate 0 SHALL therefore yield no flips, and rate 255 SHALL flip every bit except where the random byte equals 255.
REQ-009 MUTATE SHALL hold for 1 cycle with mut_start=1, mut_child=child and mut_mask=mask.
REQ-010 WAIT SHALL leave on the first cycle mut_done=1, capturing mut_child_out; mut_done outside WAIT SHALL be ignored.
REQ-011 WAIT timeout: if mut_done has not been seen after 16 cycles in WAIT, the FSM SHALL set error=1 and go to DONE without writing.
REQ-012 WRITE SHALL hold for 1 cycle with wr_en=1, wr_addr=idx and wr_data=the captured result.
REQ-013 In WRITE, mutated_count SHALL increment if mask != all-ones.
REQ-014 After WRITE, the FSM SHALL go to DONE if idx = POP_SIZE-1, else increment idx and go to READ.
REQ-015 Latency: each child SHALL take CHROMOSOME_WIDTH+5 cycles with a 1-cycle mutation unit.
REQ-016 done SHALL be high in the DONE cycle, exactly 1+POP_SIZE*(CHROMOSOME_WIDTH+5) cycles after the start-sampling edge; DONE SHALL go to IDLE.
REQ-017 rd_en, wr_en and mut_start SHALL be low in all states other than the ones named above.
REQ-018 The LFSR state SHALL persist across passes unless reloaded by start.

Reset
REQ-019 rst=1 SHALL force IDLE in any state, including mid-pass.
REQ-020 During reset, all outputs SHALL be 0 except mut_rate=8'd1, and the LFSR SHALL be 16'hACE1.
REQ-021 An interrupted pass SHALL NOT resume, and no write SHALL occur in the reset cycle.

Configuration
REQ-022 With MUTATION_ELITE_EN defined, index 0 SHALL be skipped: a pass starts at idx=1, and mutated_count and the done timing SHALL use POP_SIZE-1 children.
REQ-023 Without MUTATION_ELITE_EN, all POP_SIZE children SHALL be processed.

Verification
REQ-024 POP_SIZE=4, width 8, rate=0, seed=16'h1234, start at edge k -> 4 writes with data unchanged; done at cycle k+53; mutated_count=0.
REQ-025 rate=255, child 8'h00 -> each written byte equals ~mask; mutated_count=4 unless a mask is all-ones; results match a reference LFSR model.
REQ-026 Hold mut_done=0 in WAIT -> after 16 WAIT cycles error=1 and a done pulse, no wr_en for that child, then IDLE.
REQ-027 Assert rst during GEN of child 2 -> next cycle IDLE with busy=0 and outputs zero; a new start reprocesses from idx 0.
REQ-028 start pulses while busy, plus seed=0 -> extra starts ignored; LFSR loads 16'hACE1.
REQ-029 With MUTATION_ELITE_EN defined -> no access to address 0; done at k+40 for POP_SIZE=4.
